// File: rtl/ifetch_queue_if.sv
// Bus between the instruction prefetch queue, instruction memory, ID (redirect) and IF (deq/head).
// The master modport is the queue side; slave is the environment it talks to.
interface ifetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;

    modport master (
        output imem_req, imem_addr, valid, instr, pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, deq
    );

    modport slave (
        input  imem_req, imem_addr, valid, instr, pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, deq
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: sequential req/ack fetches into a DEPTH-entry {pc, instr} ring.
// Define IFQ_BYPASS_EN to present an acked word combinationally when the queue is empty.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic           clk,
    input  logic           reset,
    ifetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic {S_FETCH, S_DROP} state_e;

    state_e           state_q, state_d;
    logic [31:0]      fpc_q, fpc_d;
    logic [31:0]      saved_pc_q, saved_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      hold_pc_q, hold_instr_q;
    logic [63:0]      buf_q [DEPTH];

    logic        req, fire, push, pop, flush, bypass, nonempty, valid;
    logic [31:0] rpc, pc_out, instr_out;
    logic [63:0] head;

    assign rpc      = bus.redirect_pc & ~32'h3;
    assign flush    = bus.redirect;
    assign nonempty = (count_q != '0);
    assign fire     = req & bus.imem_ack;
    assign head     = buf_q[rd_ptr_q];

`ifdef IFQ_BYPASS_EN
    assign bypass = (state_q == S_FETCH) & fire & ~flush & ~nonempty;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word consumed in the same cycle never lands in the ring.
    assign push = (state_q == S_FETCH) & fire & ~flush & ~(bypass & bus.deq);
    assign pop  = bus.deq & nonempty & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        saved_pc_d = saved_pc_q;
        case (state_q)
            S_FETCH: begin
                if (flush) begin
                    // A pending request cannot be withdrawn; ride it out in DROP.
                    if (req && !bus.imem_ack) begin
                        state_d    = S_DROP;
                        saved_pc_d = rpc;
                    end else begin
                        fpc_d = rpc;
                    end
                end else if (fire) begin
                    fpc_d = fpc_q + 32'd4;
                end
            end
            S_DROP: begin
                if (flush) saved_pc_d = rpc;
                if (bus.imem_ack) begin
                    state_d = S_FETCH;
                    fpc_d   = flush ? rpc : saved_pc_q;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        req = 1'b0;
        case (state_q)
            S_FETCH: req = (count_q != CNT_FULL);
            S_DROP:  req = 1'b1;
            default: req = 1'b0;
        endcase
        if (reset) req = 1'b0;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = rd_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q        <= RESET_PC;
            saved_pc_q   <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            hold_pc_q    <= RESET_PC;
            hold_instr_q <= '0;
        end else begin
            fpc_q      <= fpc_d;
            saved_pc_q <= saved_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            // Remember whatever was last shown so the head holds once valid drops.
            if (valid) begin
                hold_pc_q    <= pc_out;
                hold_instr_q <= instr_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_q[wr_ptr_q] <= {fpc_q, bus.imem_rdata};
    end

    always_comb begin
        valid     = nonempty | bypass;
        pc_out    = hold_pc_q;
        instr_out = hold_instr_q;
        if (nonempty) begin
            pc_out    = head[63:32];
            instr_out = head[31:0];
        end else if (bypass) begin
            pc_out    = fpc_q;
            instr_out = bus.imem_rdata;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = fpc_q;
    assign bus.valid     = valid;
    assign bus.pc        = pc_out;
    assign bus.instr     = instr_out;
endmodule
